// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the Common Data Bus: grants at most one execution-unit
// result per cycle and registers it onto the bus the following cycle.
module cdb_arbiter #(
    parameter int N      = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic [N*TAG_W-1:0]  req_tag,
    input  logic [N*DATA_W-1:0] req_data,
    input  logic [N-1:0]        req_branch,
    input  logic [N-1:0]        req_branch_taken,
    input  logic [N-1:0]        req_jalr,
    input  logic [N-1:0]        req_store_pc,
    output logic [N-1:0]        grant,
    output logic                cdb_valid,
    output logic [TAG_W-1:0]    cdb_tag,
    output logic [DATA_W-1:0]   cdb_data,
    output logic                cdb_branch,
    output logic                cdb_branch_taken,
    output logic                cdb_jalr,
    output logic                cdb_store_pc,
    output logic [PTR_W-1:0]    rr_ptr
);

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  gidx, cand;
    logic              found;
    logic              valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              br_q, br_d, bt_q, bt_d, jalr_q, jalr_d, spc_q, spc_d;

    // Search starts at rr_ptr and wraps; first requester wins. Reset blocks all grants.
    always_comb begin
        gidx  = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = PTR_W'((int'(rr_ptr_q) + k) % N);
            if (!found && !rst && req[cand]) begin
                found = 1'b1;
                gidx  = cand;
            end
        end
        grant = '0;
        if (found) grant[gidx] = 1'b1;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        valid_d  = 1'b0;
        tag_d    = '0;
        data_d   = '0;
        br_d     = 1'b0;
        bt_d     = 1'b0;
        jalr_d   = 1'b0;
        spc_d    = 1'b0;
        if (found) begin
            rr_ptr_d = (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
            valid_d  = 1'b1;
            tag_d    = req_tag[int'(gidx)*TAG_W +: TAG_W];
            data_d   = req_data[int'(gidx)*DATA_W +: DATA_W];
            br_d     = req_branch[gidx];
            // Taken is only meaningful for a branch result.
            bt_d     = req_branch[gidx] & req_branch_taken[gidx];
            jalr_d   = req_jalr[gidx];
            spc_d    = req_store_pc[gidx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            valid_q  <= 1'b0;
            tag_q    <= '0;
            data_q   <= '0;
            br_q     <= 1'b0;
            bt_q     <= 1'b0;
            jalr_q   <= 1'b0;
            spc_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
            br_q     <= br_d;
            bt_q     <= bt_d;
            jalr_q   <= jalr_d;
            spc_q    <= spc_d;
        end
    end

    assign rr_ptr           = rr_ptr_q;
    assign cdb_valid        = valid_q;
    assign cdb_tag          = tag_q;
    assign cdb_data         = data_q;
    assign cdb_branch       = br_q;
    assign cdb_branch_taken = bt_q;
    assign cdb_jalr         = jalr_q;
    assign cdb_store_pc     = spc_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a bench-side round-robin model predicts each
// grant and queues the bus word expected on the following edge.
module tb_cdb_arbiter;

    localparam int N = 4, TAG_W = 6, DATA_W = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req, req_branch, req_branch_taken, req_jalr, req_store_pc;
    logic [N*TAG_W-1:0]  req_tag;
    logic [N*DATA_W-1:0] req_data;
    logic [N-1:0]        grant;
    logic                cdb_valid, cdb_branch, cdb_branch_taken, cdb_jalr, cdb_store_pc;
    logic [TAG_W-1:0]    cdb_tag;
    logic [DATA_W-1:0]   cdb_data;
    logic [1:0]          rr_ptr;

    cdb_arbiter #(.N(N), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_tag(req_tag), .req_data(req_data),
        .req_branch(req_branch), .req_branch_taken(req_branch_taken),
        .req_jalr(req_jalr), .req_store_pc(req_store_pc), .grant(grant),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_branch(cdb_branch), .cdb_branch_taken(cdb_branch_taken),
        .cdb_jalr(cdb_jalr), .cdb_store_pc(cdb_store_pc), .rr_ptr(rr_ptr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             v;
        logic [TAG_W-1:0] tag;
        logic [DATA_W-1:0] data;
        logic br, bt, jl, sp;
        logic [1:0] ptr;
    } bus_t;

    int          tests = 0, fails = 0;
    int          m_ptr = 0;
    bus_t        sb[$];
    logic [5:0]  tag_a  [N];
    logic [31:0] data_a [N];

    function automatic int pick(input logic [N-1:0] r, input logic rs, input int p);
        if (rs) return -1;
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    function automatic bus_t exp_bus(input int g);
        bus_t e;
        e = '0;
        if (rst) return e;
        e.ptr = 2'(m_ptr);
        if (g >= 0) begin
            e.v = 1'b1; e.tag = tag_a[g]; e.data = data_a[g];
            e.br = req_branch[g]; e.bt = req_branch[g] & req_branch_taken[g];
            e.jl = req_jalr[g]; e.sp = req_store_pc[g];
            e.ptr = 2'((g + 1) % N);
        end
        return e;
    endfunction

    function automatic bus_t act_bus();
        return {cdb_valid, cdb_tag, cdb_data, cdb_branch, cdb_branch_taken,
                cdb_jalr, cdb_store_pc, rr_ptr};
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_tag[i*TAG_W +: TAG_W]    = tag_a[i];
            req_data[i*DATA_W +: DATA_W] = data_a[i];
        end
    endtask

    task automatic set_payloads(input int seed);
        for (int i = 0; i < N; i++) begin
            tag_a[i]  = 6'((seed * 7 + i * 13 + 3) % 64);
            data_a[i] = 32'h1000_0000 * (i + 1) + 32'(seed);
        end
    endtask

    task automatic test_reset();
        bus_t e;
        rst = 1'b1; req = 4'b1111; set_payloads(1); drive(); #2;
        tests++;
        if (grant !== 4'b0000) begin fails++; $display("FAIL reset_grant: got %b want 0000", grant); end
        sb.push_back(exp_bus(-1)); m_ptr = 0;
        @(posedge clk); #1;
        e = sb.pop_front(); tests++;
        if (act_bus() !== e) begin fails++; $display("FAIL reset_bus: got %h want %h", act_bus(), e); end
        rst = 1'b0; req = 4'b0000; #2;
        sb.push_back(exp_bus(-1));
        @(posedge clk); #1;
        e = sb.pop_front(); tests++;
        if (act_bus() !== e) begin fails++; $display("FAIL reset_release_bus: got %h want %h", act_bus(), e); end
    endtask

    task automatic test_single();
        bus_t e; int g;
        req = 4'b0100; tag_a[2] = 6'd17; data_a[2] = 32'hDEAD_BEEF; drive(); #2;
        g = pick(req, rst, m_ptr); tests++;
        if (grant !== onehot(g) || g != 2) begin fails++; $display("FAIL single_grant: got %b want 0100", grant); end
        sb.push_back(exp_bus(g)); m_ptr = (g + 1) % N;
        @(posedge clk); #1;
        e = sb.pop_front(); tests++;
        if (act_bus() !== e || cdb_tag !== 6'd17 || cdb_data !== 32'hDEAD_BEEF || rr_ptr !== 2'd3) begin
            fails++; $display("FAIL single_bus: got %h want %h", act_bus(), e);
        end
    endtask

    task automatic test_contention();
        bus_t e; int g;
        rst = 1'b1; #2; @(posedge clk); #1; rst = 1'b0; m_ptr = 0;
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            set_payloads(c + 10); drive(); #2;
            g = pick(req, rst, m_ptr); tests++;
            if (grant !== onehot(c % N)) begin fails++; $display("FAIL contention_grant[%0d]: got %b want %b", c, grant, onehot(c % N)); end
            sb.push_back(exp_bus(g)); m_ptr = (g + 1) % N;
            @(posedge clk); #1;
            e = sb.pop_front(); tests++;
            if (act_bus() !== e) begin fails++; $display("FAIL contention_bus[%0d]: got %h want %h", c, act_bus(), e); end
        end
    endtask

    task automatic test_wrap_skip();
        bus_t e; int g;
        logic [N-1:0] pats [3] = '{4'b0100, 4'b0011, 4'b0011};
        int           want [3] = '{2, 0, 1};
        for (int c = 0; c < 3; c++) begin
            req = pats[c]; set_payloads(c + 30); drive(); #2;
            g = pick(req, rst, m_ptr); tests++;
            if (grant !== onehot(want[c])) begin fails++; $display("FAIL wrap_grant[%0d]: got %b want %b", c, grant, onehot(want[c])); end
            sb.push_back(exp_bus(g)); m_ptr = (g + 1) % N;
            @(posedge clk); #1;
            e = sb.pop_front(); tests++;
            if (act_bus() !== e) begin fails++; $display("FAIL wrap_bus[%0d]: got %h want %h", c, act_bus(), e); end
        end
    endtask

    task automatic test_flags();
        bus_t e; int g;
        logic [N-1:0] rq [3] = '{4'b0001, 4'b0001, 4'b0010};
        logic [N-1:0] br [3] = '{4'b0001, 4'b0000, 4'b0000};
        logic [N-1:0] bt [3] = '{4'b0001, 4'b0001, 4'b0000};
        logic [N-1:0] jl [3] = '{4'b0000, 4'b0000, 4'b0010};
        logic [N-1:0] sp [3] = '{4'b0000, 4'b0000, 4'b0010};
        rst = 1'b1; #2; @(posedge clk); #1; rst = 1'b0; m_ptr = 0;
        for (int c = 0; c < 3; c++) begin
            req = rq[c]; req_branch = br[c]; req_branch_taken = bt[c];
            req_jalr = jl[c]; req_store_pc = sp[c];
            set_payloads(c + 50); drive(); #2;
            g = pick(req, rst, m_ptr); tests++;
            if (grant !== onehot(g)) begin fails++; $display("FAIL flags_grant[%0d]: got %b want %b", c, grant, onehot(g)); end
            sb.push_back(exp_bus(g)); m_ptr = (g + 1) % N;
            @(posedge clk); #1;
            e = sb.pop_front(); tests++;
            if (act_bus() !== e) begin fails++; $display("FAIL flags_bus[%0d]: got %h want %h", c, act_bus(), e); end
        end
        req_branch = '0; req_branch_taken = '0; req_jalr = '0; req_store_pc = '0;
    endtask

    task automatic test_idle_midreset();
        bus_t e; int g;
        logic [N-1:0] rq [7] = '{4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
        logic         rs [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int c = 0; c < 7; c++) begin
            req = rq[c]; rst = rs[c]; set_payloads(c + 70); drive(); #2;
            g = pick(req, rst, m_ptr); tests++;
            if (grant !== onehot(g)) begin fails++; $display("FAIL midrst_grant[%0d]: got %b want %b", c, grant, onehot(g)); end
            sb.push_back(exp_bus(g));
            m_ptr = rst ? 0 : (g >= 0) ? (g + 1) % N : m_ptr;
            @(posedge clk); #1;
            e = sb.pop_front(); tests++;
            if (act_bus() !== e) begin fails++; $display("FAIL midrst_bus[%0d]: got %h want %h", c, act_bus(), e); end
        end
        rst = 1'b0; req = '0;
    endtask

    initial begin
        rst = 1'b1; req = '0; req_branch = '0; req_branch_taken = '0;
        req_jalr = '0; req_store_pc = '0; req_tag = '0; req_data = '0;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_contention();
        test_wrap_skip();
        test_flags();
        test_idle_midreset();
        if (sb.size() != 0) begin
            tests++; fails++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
